// File: rtl/query_dispatch_if.sv
// Query stream from upstream plus broadcast/per-engine handshakes toward the alignment engines.
// master: the scheduler side; slave: upstream source and engines.
interface query_dispatch_if #(
    parameter int NUM_ENGINES = 4,
    parameter int NUM_PES     = 64
);
    logic [25:0]              q_ref_length;
    logic [25:0]              q_ref_addr;
    logic [15:0]              q_num_blocks;
    logic [15:0]              q_id;
    logic [31:0]              q_threshold;
    logic                     q_info_valid;
    logic                     q_info_rdy;
    logic [NUM_PES*2-1:0]     q_block;
    logic                     q_block_valid;
    logic                     q_block_rdy;

    logic [25:0]              e_ref_length;
    logic [25:0]              e_ref_addr;
    logic [15:0]              e_num_blocks;
    logic [15:0]              e_id;
    logic [31:0]              e_threshold;
    logic [NUM_PES*2-1:0]     e_block;
    logic [NUM_ENGINES-1:0]   e_info_valid;
    logic [NUM_ENGINES-1:0]   e_info_rdy;
    logic [NUM_ENGINES-1:0]   e_block_valid;
    logic [NUM_ENGINES-1:0]   e_block_rdy;
    logic [NUM_ENGINES-1:0]   e_done;
    logic [NUM_ENGINES-1:0]   e_busy;
    logic [3:0]               sel_engine;

    modport master (
        input  q_ref_length, q_ref_addr, q_num_blocks, q_id, q_threshold,
        input  q_info_valid, q_block, q_block_valid,
        output q_info_rdy, q_block_rdy,
        output e_ref_length, e_ref_addr, e_num_blocks, e_id, e_threshold, e_block,
        output e_info_valid, e_block_valid, e_busy, sel_engine,
        input  e_info_rdy, e_block_rdy, e_done
    );

    modport slave (
        output q_ref_length, q_ref_addr, q_num_blocks, q_id, q_threshold,
        output q_info_valid, q_block, q_block_valid,
        input  q_info_rdy, q_block_rdy,
        input  e_ref_length, e_ref_addr, e_num_blocks, e_id, e_threshold, e_block,
        input  e_info_valid, e_block_valid, e_busy, sel_engine,
        output e_info_rdy, e_block_rdy, e_done
    );
endinterface

// File: rtl/query_dispatch_scheduler.sv
// Round-robin dispatch of queries (info + blocks) to the first idle alignment engine.
// Optional QUERY_DISPATCH_STATS_EN adds query and stall counters.
module query_dispatch_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int NUM_PES     = 64
) (
    input  logic                clk,
    input  logic                rst,
    query_dispatch_if.master    bus
`ifdef QUERY_DISPATCH_STATS_EN
    ,
    output logic [31:0]         stat_queries,
    output logic [31:0]         stat_stall_cycles
`endif
);
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] SELECT      = 2'd1;
    localparam logic [1:0] SEND_INFO   = 2'd2;
    localparam logic [1:0] SEND_BLOCKS = 2'd3;

    logic [1:0]             state;
    logic [NUM_ENGINES-1:0] busy;
    logic [3:0]             rr_ptr;
    logic [3:0]             sel;
    logic [15:0]            cnt;
    logic [15:0]            num_blocks;

    logic [NUM_ENGINES-1:0] sel_mask;
    logic [NUM_ENGINES-1:0] set_mask;
    logic [3:0]             pick;
    logic [3:0]             rr_next;
    logic                   info_hs;
    logic                   block_hs;
    logic [NUM_PES*2-1:0]   block_fwd;

    assign block_fwd        = bus.q_block;
    assign bus.e_block      = block_fwd;
    assign bus.e_ref_length = bus.q_ref_length;
    assign bus.e_ref_addr   = bus.q_ref_addr;
    assign bus.e_num_blocks = bus.q_num_blocks;
    assign bus.e_id         = bus.q_id;
    assign bus.e_threshold  = bus.q_threshold;

    assign sel_mask = NUM_ENGINES'(1) << sel;
    assign rr_next  = (sel == 4'(NUM_ENGINES - 1)) ? 4'd0 : sel + 4'd1;

    assign bus.q_info_rdy    = (state == SEND_INFO)   && (|(bus.e_info_rdy & sel_mask));
    assign bus.q_block_rdy   = (state == SEND_BLOCKS) && (|(bus.e_block_rdy & sel_mask));
    assign bus.e_info_valid  = (state == SEND_INFO   && bus.q_info_valid)  ? sel_mask : '0;
    assign bus.e_block_valid = (state == SEND_BLOCKS && bus.q_block_valid) ? sel_mask : '0;
    assign bus.e_busy        = busy;
    assign bus.sel_engine    = sel;

    assign info_hs  = bus.q_info_valid  && bus.q_info_rdy;
    assign block_hs = bus.q_block_valid && bus.q_block_rdy;
    assign set_mask = info_hs ? sel_mask : '0;

    // First idle engine scanning upward from rr_ptr with wraparound
    always_comb begin
        int  cand;
        logic found;
        pick  = rr_ptr;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_ENGINES;
            if (!found && !(|(busy & (NUM_ENGINES'(1) << cand)))) begin
                pick  = 4'(cand);
                found = 1'b1;
            end
        end
    end

    // Busy set on info handshake takes priority over a coincident done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= '0;
            rr_ptr     <= '0;
            sel        <= '0;
            cnt        <= '0;
            num_blocks <= '0;
        end else begin
            busy <= (busy & ~bus.e_done) | set_mask;
            case (state)
                IDLE: begin
                    if (bus.q_info_valid && !(&busy))
                        state <= SELECT;
                end
                SELECT: begin
                    sel   <= pick;
                    state <= SEND_INFO;
                end
                SEND_INFO: begin
                    if (info_hs) begin
                        num_blocks <= bus.q_num_blocks;
                        cnt        <= '0;
                        rr_ptr     <= rr_next;
                        state      <= (bus.q_num_blocks == 16'd0) ? IDLE : SEND_BLOCKS;
                    end
                end
                SEND_BLOCKS: begin
                    if (block_hs) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == num_blocks - 16'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef QUERY_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_queries      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (info_hs)
                stat_queries <= stat_queries + 32'd1;
            if (state == IDLE && bus.q_info_valid && (&busy))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_query_dispatch_scheduler.sv
// Directed bench for query_dispatch_scheduler: dispatch order, back-pressure, zero-block queries, reset abort.
module tb_query_dispatch_scheduler;
    localparam int NE = 4;
    localparam int NP = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    query_dispatch_if #(.NUM_ENGINES(NE), .NUM_PES(NP)) bus ();

`ifdef QUERY_DISPATCH_STATS_EN
    logic [31:0] stat_queries;
    logic [31:0] stat_stall_cycles;
`endif

    query_dispatch_scheduler #(.NUM_ENGINES(NE), .NUM_PES(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef QUERY_DISPATCH_STATS_EN
        ,
        .stat_queries      (stat_queries),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int qnum   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [NP*2-1:0] blk_pat(input int q, input int b);
        return {16'(q), 16'(b), 96'h5A5AC3C3_0F0F1234_9876ABCD};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        settle();
        chk("rst_info_rdy",    bus.q_info_rdy,    0);
        chk("rst_block_rdy",   bus.q_block_rdy,   0);
        chk("rst_info_valid",  bus.e_info_valid,  0);
        chk("rst_block_valid", bus.e_block_valid, 0);
        chk("rst_busy",        bus.e_busy,        0);
        chk("rst_sel",         bus.sel_engine,    0);
        rst = 1'b0;
    endtask

    task automatic free_all();
        bus.e_done = '1;
        tick();
        bus.e_done = '0;
        settle();
        chk("free_all_busy", bus.e_busy, 0);
    endtask

    // One query: info handshake to engine eng, then nb blocks; optional toggling
    // block-ready, done pulse on the info handshake, and reset after abort_at blocks.
    task automatic send_query(input int nb, input int eng, input bit toggle,
                              input bit done_hs, input int abort_at);
        int waited;
        int c;
        int b;
        logic rdy;
        qnum++;
        bus.q_num_blocks = 16'(nb);
        bus.q_id         = 16'(qnum);
        bus.q_ref_addr   = 26'(qnum * 100);
        bus.q_ref_length = 26'(qnum * 7);
        bus.q_threshold  = 32'(qnum + 1000);
        bus.q_info_valid = 1'b1;
        bus.e_info_rdy   = '1;
        settle();
        waited = 0;
        while (!bus.q_info_rdy && waited < 20) begin
            tick();
            settle();
            waited++;
        end
        chk("info_rdy",   bus.q_info_rdy,   1);
        chk("info_valid", bus.e_info_valid, NE'(1) << eng);
        chk("sel_engine", bus.sel_engine,   eng);
        chk("e_id",       bus.e_id,         qnum);
        chk("e_ref_addr", bus.e_ref_addr,   qnum * 100);
        if (done_hs) bus.e_done = NE'(1) << eng;
        tick();
        bus.e_done       = '0;
        bus.q_info_valid = 1'b0;
        settle();
        chk("busy_set", bus.e_busy[eng], 1);
        c = 0;
        b = 0;
        while (b < nb && c < 40) begin
            if (abort_at >= 0 && b == abort_at) begin
                bus.q_block_valid = 1'b1;
                do_reset();
                bus.q_block_valid = 1'b0;
                return;
            end
            rdy = toggle ? c[0] : 1'b1;
            bus.q_block       = blk_pat(qnum, b);
            bus.q_block_valid = 1'b1;
            bus.e_block_rdy   = rdy ? '1 : ~(NE'(1) << eng);
            settle();
            chk("blk_rdy",   bus.q_block_rdy,   rdy);
            chk("blk_valid", bus.e_block_valid, NE'(1) << eng);
            chk("blk_data",  bus.e_block,       blk_pat(qnum, b));
            tick();
            if (rdy) b++;
            c++;
        end
        chk("blocks_sent", b, nb);
        bus.q_block_valid = 1'b1;
        bus.e_block_rdy   = '1;
        settle();
        chk("idle_block_rdy",   bus.q_block_rdy,   0);
        chk("idle_block_valid", bus.e_block_valid, 0);
        chk("idle_info_rdy",    bus.q_info_rdy,    0);
        bus.q_block_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.q_ref_length  = '0;
        bus.q_ref_addr    = '0;
        bus.q_num_blocks  = '0;
        bus.q_id          = '0;
        bus.q_threshold   = '0;
        bus.q_info_valid  = 1'b0;
        bus.q_block       = '0;
        bus.q_block_valid = 1'b0;
        bus.e_info_rdy    = '0;
        bus.e_block_rdy   = '0;
        bus.e_done        = '0;
        tick();
        do_reset();

        // Single 3-block query lands on engine 0
        send_query(3, 0, 1'b0, 1'b0, -1);
        chk("t1_busy", bus.e_busy, 4'b0001);

        // Four back-to-back queries fill every engine, fifth stalls until engine 2 frees
        do_reset();
        for (int e = 0; e < NE; e++) send_query(1, e, 1'b0, 1'b0, -1);
        chk("t2_all_busy", bus.e_busy, 4'b1111);
        bus.q_info_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            settle();
            chk("t2_hold_rdy",   bus.q_info_rdy,   0);
            chk("t2_hold_valid", bus.e_info_valid, 0);
        end
        bus.e_done = 4'b0100;
        tick();
        bus.e_done = '0;
        settle();
        chk("t2_done2_busy", bus.e_busy, 4'b1011);
        send_query(1, 2, 1'b0, 1'b0, -1);
        chk("t2_busy_after", bus.e_busy, 4'b1111);
`ifdef QUERY_DISPATCH_STATS_EN
        chk("stat_queries",      stat_queries,      5);
        chk("stat_stall_cycles", stat_stall_cycles, 11);
`endif

        // Done on an idle engine is ignored; zero-block query then a normal one
        free_all();
        bus.e_done = 4'b0001;
        tick();
        bus.e_done = '0;
        settle();
        chk("t3_idle_done", bus.e_busy, 0);
        send_query(0, 3, 1'b0, 1'b0, -1);
        chk("t3_busy_zero", bus.e_busy, 4'b1000);
        send_query(1, 0, 1'b0, 1'b0, -1);
        chk("t3_busy_next", bus.e_busy, 4'b1001);

        // Toggling block-ready on engine 1
        send_query(4, 1, 1'b1, 1'b0, -1);
        chk("t4_busy", bus.e_busy, 4'b1011);

        // Done coinciding with info handshake: set wins
        send_query(0, 2, 1'b0, 1'b1, -1);
        chk("t5_busy", bus.e_busy, 4'b1111);

        // Move rr_ptr to 1, then abort a 5-block query after 2 blocks
        free_all();
        send_query(0, 3, 1'b0, 1'b0, -1);
        send_query(0, 0, 1'b0, 1'b0, -1);
        free_all();
        send_query(5, 1, 1'b0, 1'b0, 2);
        chk("t6_busy_after_rst", bus.e_busy, 0);
        send_query(1, 0, 1'b0, 1'b0, -1);
        chk("t6_busy_final", bus.e_busy, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
